// File: rtl/branch_predictor_2lvl.sv
// branch_predictor_2lvl
//
// Two-level branch predictor for the pipelined MIPS datapath.
// Lookup is purely combinational from the fetch PC. Training uses the
// resolved outcome and the indices carried down the pipe to the M stage,
// so tables only ever hold non-speculative state.
//
// Parameters:
//   PC_HASH_BITS   : BHT index width (2^PC_HASH_BITS history entries)
//   HIST_BITS      : history length; must not exceed PHT_INDEX_BITS
//   PHT_INDEX_BITS : PHT index width (2^PHT_INDEX_BITS counters)
//   CTR_BITS       : saturating counter width (>= 1)
//   MODE           : 0 = per-PC local history, 1 = single global history
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   pcF             : fetch PC
//   predict_takeF   : prediction for pcF
//   pc_hashingF     : BHT index for pcF, carried down the pipe
//   PHT_indexF      : PHT index for pcF, carried down the pipe
//   branchM         : M-stage instruction is a branch (update enable)
//   actually_takenM : resolved branch direction
//   predict_resultM : 1 when the prediction was correct (1 for non-branches)
//   pc_hashingM     : BHT index returned with the branch
//   PHT_indexM      : PHT index returned with the branch
//   branch_cnt      : retired branch count
//   mispredict_cnt  : mispredicted branch count
//
// Optional build macro BP_PERF_CNT_EN adds saturating 32-bit counters behind
// branch_cnt / mispredict_cnt. Without it both outputs are tied to zero.

module branch_predictor_2lvl #(
  parameter int PC_HASH_BITS   = 3,
  parameter int HIST_BITS      = 4,
  parameter int PHT_INDEX_BITS = 7,
  parameter int CTR_BITS       = 2,
  parameter int MODE           = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pcF,
  output logic                      predict_takeF,
  output logic [PC_HASH_BITS-1:0]   pc_hashingF,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  input  logic                      branchM,
  input  logic                      actually_takenM,
  input  logic                      predict_resultM,
  input  logic [PC_HASH_BITS-1:0]   pc_hashingM,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexM,
  output logic [31:0]               branch_cnt,
  output logic [31:0]               mispredict_cnt
);

  localparam int BhtEntries = 1 << PC_HASH_BITS;
  localparam int PhtEntries = 1 << PHT_INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CtrWeakNt = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CtrMax    = '1;

  if (HIST_BITS > PHT_INDEX_BITS) begin : gBadHist
    $error("HIST_BITS (%0d) must be <= PHT_INDEX_BITS (%0d)", HIST_BITS, PHT_INDEX_BITS);
  end
  if (CTR_BITS < 1) begin : gBadCtr
    $error("CTR_BITS must be >= 1");
  end

  logic [HIST_BITS-1:0] histF;
  logic [HIST_BITS-1:0] histM;
  logic [HIST_BITS-1:0] histNext;

  // Shift in the outcome; the truncating cast drops the oldest bit and also
  // covers HIST_BITS == 1, where the history is just the last outcome.
  assign histNext = HIST_BITS'({histM, actually_takenM});

  // ---------------------------------------------------------------------------
  // History storage
  // ---------------------------------------------------------------------------
  if (MODE == 0) begin : gLocal
    logic [HIST_BITS-1:0] bhtQ [BhtEntries];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < BhtEntries; i++) begin
          bhtQ[i] <= '0;
        end
      end else if (branchM) begin
        bhtQ[pc_hashingM] <= histNext;
      end
    end

    assign histF = bhtQ[pc_hashingF];
    assign histM = bhtQ[pc_hashingM];
  end else begin : gGlobal
    logic [HIST_BITS-1:0] ghrQ;
    logic                 unusedHashM;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ghrQ <= '0;
      end else if (branchM) begin
        ghrQ <= histNext;
      end
    end

    assign histF       = ghrQ;
    assign histM       = ghrQ;
    assign unusedHashM = ^pc_hashingM;
  end

  // ---------------------------------------------------------------------------
  // Pattern history table
  // ---------------------------------------------------------------------------
  logic [CTR_BITS-1:0] phtQ [PhtEntries];
  logic [CTR_BITS-1:0] ctrM;
  logic [CTR_BITS-1:0] ctrNext;

  assign ctrM = phtQ[PHT_indexM];

  always_comb begin
    ctrNext = ctrM;
    if (actually_takenM) begin
      if (ctrM != CtrMax) ctrNext = ctrM + 1'b1;
    end else begin
      if (ctrM != '0) ctrNext = ctrM - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PhtEntries; i++) begin
        phtQ[i] <= CtrWeakNt;
      end
    end else if (branchM) begin
      phtQ[PHT_indexM] <= ctrNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup (no bypass: a same-cycle update becomes visible after the edge)
  // ---------------------------------------------------------------------------
  logic unusedPc;

  assign pc_hashingF   = pcF[PC_HASH_BITS+1:2];
  assign PHT_indexF    = pcF[PHT_INDEX_BITS+1:2] ^ PHT_INDEX_BITS'(histF);
  assign predict_takeF = phtQ[PHT_indexF][CTR_BITS-1];
  assign unusedPc      = ^{pcF[31:PHT_INDEX_BITS+2], pcF[1:0]};

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef BP_PERF_CNT_EN
  logic [31:0] branchCntQ;
  logic [31:0] mispredictCntQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branchCntQ     <= '0;
      mispredictCntQ <= '0;
    end else if (branchM) begin
      if (branchCntQ != '1) branchCntQ <= branchCntQ + 32'd1;
      if (!predict_resultM && (mispredictCntQ != '1)) begin
        mispredictCntQ <= mispredictCntQ + 32'd1;
      end
    end
  end

  assign branch_cnt     = branchCntQ;
  assign mispredict_cnt = mispredictCntQ;
`else
  logic unusedPerfIn;

  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
  assign unusedPerfIn   = predict_resultM;
`endif

endmodule

// File: doc/branch_predictor_2lvl.md
Name: branch_predictor_2lvl

Overview:
- Parametrised two-level branch predictor feeding the pipelined MIPS datapath.
- Looks up a prediction combinationally from pcF in IF, and produces predict_takeF, pc_hashingF and PHT_indexF for the datapath's IF/ID pipeline registers.
- Trains non-speculatively from the M-stage signals returned by the datapath (branchM, actually_takenM, pc_hashingM, PHT_indexM).
- Supports local (per-PC history table) or global (single history register) mode, with configurable table sizes and counter width.

Parameters:
- PC_HASH_BITS, 3: BHT index width; BHT has 2^PC_HASH_BITS entries.
- HIST_BITS, 4: history length per BHT entry or GHR; must be <= PHT_INDEX_BITS, otherwise $error at elaboration.
- PHT_INDEX_BITS, 7: PHT index width; PHT has 2^PHT_INDEX_BITS counters.
- CTR_BITS, 2: saturating counter width, >= 1.
- MODE, 0: 0 = local history (BHT indexed by pc_hashing); 1 = global history (single GHR).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- pcF  input  32  fetch PC.
- predict_takeF  output  1  prediction for pcF.
- pc_hashingF  output  PC_HASH_BITS  pcF[PC_HASH_BITS+1:2].
- PHT_indexF  output  PHT_INDEX_BITS  PHT index used for this lookup.
- branchM  input  1  M-stage instruction is a branch (update enable).
- actually_takenM  input  1  resolved branch outcome.
- predict_resultM  input  1  1 = prediction correct (also 1 for non-branch).
- pc_hashingM  input  PC_HASH_BITS  BHT index carried with the branch.
- PHT_indexM  input  PHT_INDEX_BITS  PHT index carried with the branch.
- branch_cnt  output  32  retired branch count (optional feature).
- mispredict_cnt  output  32  mispredicted branch count (optional feature).

Behaviour:
- Reset (async, immediate on rst=1):
  - all BHT entries and the GHR = 0;
  - all PHT counters = weakly not-taken, value 2^(CTR_BITS-1)-1 (01 for 2 bits);
  - counters branch_cnt and mispredict_cnt = 0.
  - Consequently, with rst=1, predict_takeF = 0 for any pcF.
- Lookup (combinational, zero latency):
  - hist = BHT[pc_hashingF] in MODE 0, or GHR in MODE 1.
  - PHT_indexF = pcF[PHT_INDEX_BITS+1:2] XOR zero-extend(hist).
  - predict_takeF = MSB of PHT[PHT_indexF].
- Update, at the rising clk edge when branchM=1:
  - PHT[PHT_indexM]: +1 if actually_takenM, -1 otherwise; saturates at 2^CTR_BITS-1 and at 0.
  - History: MODE 0 updates BHT[pc_hashingM]; MODE 1 updates the GHR. The new value is {hist[HIST_BITS-2:0], actually_takenM}. With HIST_BITS=1 the history is simply actually_takenM.
  - With branchM=0, no state changes regardless of the other M inputs.
- Lookup and update on the same cycle to the same entry: the lookup returns the pre-update value (no bypass). The new value is visible from the cycle after the edge.
- The inputs PHT_indexM and pc_hashingM are trusted as given; the predictor performs no consistency check against the original lookup.
- Reset asserted mid-operation: an in-flight update on the same edge is discarded, and reset wins.
- No stall input: lookup is purely combinational, so stalling is handled by the datapath's IF/ID registers.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined:
  - branch_cnt increments on each edge with branchM=1.
  - mispredict_cnt increments on each edge with branchM=1 and predict_resultM=0.
  - Both saturate at 32'hFFFF_FFFF.
  - predict_resultM=0 with branchM=0 is ignored.
- Undefined: no counter flops; branch_cnt and mispredict_cnt are tied to 0. Ports are present in both builds.

Test Plan:
- Reset lookup (defaults): after reset, pcF=32'h0040_0010 -> pc_hashingF=3'd4, PHT_indexF=7'h04, predict_takeF=0.
- Local training (MODE 0): one update with branchM=1, actually_takenM=1, pc_hashingM=5, PHT_indexM=7'h04 -> BHT[5]=4'b0001, PHT[0x04]=2'b10. Then pcF=32'h0040_0014 -> PHT_indexF=7'h05^7'h01=7'h04, predict_takeF=1.
- Saturation (MODE 1): with PHT_indexM=7'h20 held, drive 4 taken updates then 2 not-taken updates.
  - PHT[0x20] sequence: 01->10->11->11->11->10->01.
  - Final GHR=4'b1100.
  - Lookup pcF=32'h0040_0080 (slice 0x20) -> PHT_indexF=7'h2C.
- Same-cycle hazard: lookup of an entry at 01 while a taken update hits it -> predict_takeF=0 in that cycle and 1 in the next cycle.
- Async reset mid-run: after training, assert rst between clock edges -> predict_takeF=0 and all counters 0 without waiting for a clk edge; the update presented on the next edge while rst=1 has no effect.
- Perf counters (BP_PERF_CNT_EN):
  - 5 branch updates, 2 with predict_resultM=0, plus 3 non-branch cycles with predict_resultM=0 -> branch_cnt=5, mispredict_cnt=2.
  - Preload the counter to 32'hFFFF_FFFF via force -> the counter stays at 32'hFFFF_FFFF.
